span_expander: RTL and testbench
================================

Name: span_expander

Overview:
- Downstream consumer of the triangle span table that the rasterizer writes into SRAM.
- Each SRAM record is one horizontal span: left x, right x, row y.
- On start, the block reads span_count records sequentially from BASE_ADDR upward.
- It expands every span into one (x, y) pixel per accepted handshake and feeds the pixel/VGA fill stage.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 31, SRAM record width.
- X_W, 11, x field width (record bits [10:0] = left x, [21:11] = right x).
- Y_W, 9, y field width (record bits [30:22] = row y).
- BASE_ADDR, 15, address of the first span record.
- MEM_LAT, 1, read latency in cycles from mem_rd high to mem_data valid (1..3).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a table walk when idle.
- span_count  in  ADDR_W  number of records to read; sampled on accepted start.
- mem_addr  out  ADDR_W  SRAM read address.
- mem_rd  out  1  read strobe, one cycle per record.
- mem_data  in  DATA_W  SRAM read data, valid MEM_LAT cycles after mem_rd.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_x  out  X_W  pixel x.
- pix_y  out  Y_W  pixel y.
- pix_last  out  1  high with the final pixel of the final valid span.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of walk.
- err_cnt  out  8  saturating count of malformed records in the current walk.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; mem_addr=0; mem_rd=0; pix_valid=0; pix_x=0; pix_y=0; pix_last=0; busy=0; done=0; err_cnt=0; internal counters cleared.
- Reset mid-walk: aborts immediately, no done pulse, no further mem_rd.
- IDLE:
  - start=1 with span_count>0: latch count, clear err_cnt, set rec_idx=0, busy=1, go FETCH.
  - start=1 with span_count=0: busy stays 0, done=1 for the next cycle, stay IDLE, no mem_rd.
  - start while busy is ignored.
- FETCH (1 cycle): mem_rd=1, mem_addr=BASE_ADDR+rec_idx (ADDR_W wrap), go WAIT. mem_addr holds its value outside FETCH.
- WAIT: count MEM_LAT cycles. In the cycle mem_data is valid, capture left, right and y.
  - left>right: record is malformed; err_cnt+1 (saturates at 255); go NEXT.
  - Otherwise: cur_x=left, go EMIT.
- EMIT: pix_valid=1, pix_x=cur_x, pix_y=y.
  - Handshake = pix_valid & pix_ready.
  - While valid&!ready: pix_x, pix_y and pix_last are held stable.
  - On handshake with cur_x<right: cur_x+1, remain EMIT (one pixel per cycle at full throughput).
  - On handshake with cur_x==right: pix_valid drops next cycle, go NEXT.
  - left==right emits exactly one pixel.
- NEXT (1 cycle): rec_idx+1.
  - rec_idx+1 < count: go FETCH.
  - Otherwise: go DONE.
- DONE: done=1 for one cycle, busy=0, go IDLE.
- No prefetch. The gap between spans is 2+MEM_LAT cycles (NEXT, FETCH, WAIT).
- Latency: start sampled in cycle N → mem_rd in N+1 → first pix_valid in N+2+MEM_LAT. For MEM_LAT=1 this is N+3.
- pix_last=1 only during the final pixel of a span when rec_idx==count-1; it is registered in lookahead so it appears with that pixel.
  - If the last record is malformed, no pix_last is produced; done still pulses.
- Arithmetic: all fields unsigned; no clamping of x or y.

Test Plan:
- Single span: mem[15]={y=4,r=15,l=12}, span_count=1, pix_ready=1, start at cycle N → mem_rd at N+1 addr 15; pixels (12,4),(13,4),(14,4),(15,4) valid N+3..N+6; pix_last with (15,4); done at N+8; err_cnt=0.
- Backpressure over two spans: mem[15]={y=4,r=6,l=5}, mem[16]={y=5,r=7,l=7}; pix_ready toggles 1,0,0,1,… → pixels (5,4),(6,4),(7,5) each held stable while stalled; exactly 3 handshakes; mem_addr 15 then 16; pix_last only on (7,5).
- Empty table: span_count=0, start → no mem_rd, no pix_valid, done=1 one cycle after start, busy stays 0.
- Malformed record: mem[15]={y=2,l=20,r=10}, mem[16]={y=3,l=1,r=1}, span_count=2 → only pixel (1,3) emitted with pix_last; err_cnt=1 at done.
- Reset mid-walk: rst_n=0 for 1 cycle during EMIT of span (12..15) after 2 pixels → next cycle all outputs at reset values; a new start restarts from addr 15 with err_cnt=0.
- Start while busy: second start pulse during EMIT → ignored; walk completes with exactly span_count records read and a single done pulse.

Source files
------------

// File: rtl/span_expander.sv
// Walks the rasterizer's span table in SRAM and expands each (left, right, y) record
// into a stream of (x, y) pixels with a valid/ready handshake towards the fill stage.
module span_expander #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 31,
  parameter int X_W       = 11,
  parameter int Y_W       = 9,
  parameter int BASE_ADDR = 15,
  parameter int MEM_LAT   = 1
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] span_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              pix_last,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] rec_idx_q, rec_idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [1:0]        lat_q, lat_d;
  logic [X_W-1:0]    right_q, right_d;
  logic              last_rec_q, last_rec_d;
  logic              pix_valid_q, pix_valid_d;
  logic [X_W-1:0]    pix_x_q, pix_x_d;
  logic [Y_W-1:0]    pix_y_q, pix_y_d;
  logic              pix_last_q, pix_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [X_W-1:0]    rec_left;
  logic [X_W-1:0]    rec_right;
  logic [Y_W-1:0]    rec_y;
  logic [ADDR_W-1:0] next_idx;
  logic              is_last_rec;

  assign rec_left    = mem_data[X_W-1:0];
  assign rec_right   = mem_data[2*X_W-1:X_W];
  assign rec_y       = mem_data[2*X_W+Y_W-1:2*X_W];
  assign next_idx    = rec_idx_q + ADDR_W'(1);
  assign is_last_rec = (rec_idx_q == count_q - ADDR_W'(1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rec_idx_d   = rec_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    lat_d       = lat_q;
    right_d     = right_q;
    last_rec_d  = last_rec_q;
    pix_valid_d = pix_valid_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_last_d  = pix_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (span_count != '0) begin
            count_d    = span_count;
            err_cnt_d  = 8'd0;
            rec_idx_d  = '0;
            busy_d     = 1'b1;
            mem_rd_d   = 1'b1;
            mem_addr_d = ADDR_W'(BASE_ADDR);
            state_d    = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_FETCH: begin
        lat_d   = 2'd1;
        state_d = S_WAIT;
      end

      // The record is captured in the cycle its data arrives; pix_last is
      // decided here already so it lines up with a single-pixel span.
      S_WAIT: begin
        if (lat_q == 2'(MEM_LAT)) begin
          if (rec_left > rec_right) begin
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = S_NEXT;
          end else begin
            right_d     = rec_right;
            last_rec_d  = is_last_rec;
            pix_valid_d = 1'b1;
            pix_x_d     = rec_left;
            pix_y_d     = rec_y;
            pix_last_d  = is_last_rec && (rec_left == rec_right);
            state_d     = S_EMIT;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      S_EMIT: begin
        if (pix_valid_q && pix_ready) begin
          if (pix_x_q < right_q) begin
            pix_x_d    = pix_x_q + X_W'(1);
            pix_last_d = last_rec_q && ((pix_x_q + X_W'(1)) == right_q);
          end else begin
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            state_d     = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        rec_idx_d = next_idx;
        if (next_idx < count_q) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = ADDR_W'(BASE_ADDR) + next_idx;
          state_d    = S_FETCH;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rec_idx_q   <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      lat_q       <= 2'd0;
      right_q     <= '0;
      last_rec_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rec_idx_q   <= rec_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      lat_q       <= lat_d;
      right_q     <= right_d;
      last_rec_q  <= last_rec_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_last_q  <= pix_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_last  = pix_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_span_expander.sv
// Bench for span_expander: SRAM model, pixel/address scoreboard, vector table
// and hand-written sequences for timing, empty table, restart and reset corners.
`timescale 1ns/1ps
module tb_span_expander;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 31;
  localparam int X_W    = 11;
  localparam int Y_W    = 9;
  localparam int BASE   = 15;

  logic              CLOCK_50 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] span_count = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              pix_last;
  logic              busy;
  logic              done;
  logic [7:0]        err_cnt;

  span_expander #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W),
    .BASE_ADDR(BASE), .MEM_LAT(1)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .span_count(span_count),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // One-cycle SRAM; outside a read it returns a malformed-looking word so a
  // mistimed capture shows up as a wrong pixel or error count.
  logic [DATA_W-1:0] mem [0:511];
  always @(posedge CLOCK_50) mem_data <= mem_rd ? mem[mem_addr[8:0]] : 31'h0000_07FF;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           last;
  } pix_t;

  typedef struct {
    int              cnt;
    int              mode;
    logic [2:0][10:0] l;
    logic [2:0][10:0] r;
    logic [2:0][8:0]  y;
    int              exp_err;
    int              exp_pix;
  } vec_t;

  pix_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  vec_t              vecs[6];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setRec(input int k, input int l, input int r, input int y);
    mem[BASE+k] = {9'(y), 11'(r), 11'(l)};
  endtask

  task automatic setVec(input int v, input int cnt, input int mode, input int e, input int p);
    vecs[v].cnt = cnt; vecs[v].mode = mode; vecs[v].exp_err = e; vecs[v].exp_pix = p;
  endtask

  task automatic setVecRec(input int v, input int k, input int l, input int r, input int y);
    vecs[v].l[k] = 11'(l); vecs[v].r[k] = 11'(r); vecs[v].y[k] = 9'(y);
  endtask

  // Reference walk over the current SRAM contents.
  task automatic pushModel(input int cnt);
    logic [DATA_W-1:0] rec;
    int l, r, yv;
    pix_t p;
    for (int i = 0; i < cnt; i++) begin
      rec = mem[BASE+i];
      l = int'(rec[10:0]);
      r = int'(rec[21:11]);
      yv = int'(rec[30:22]);
      addr_q.push_back(ADDR_W'(BASE + i));
      for (int x = l; x <= r; x++) begin
        p.x = X_W'(x);
        p.y = Y_W'(yv);
        p.last = (x == r) && (i == cnt - 1);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic pulseStart(input int cnt);
    @(posedge CLOCK_50); #1;
    span_count = ADDR_W'(cnt);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int cnt, input int mode, output int hs, output int rd);
    int hs0, rd0, d0;
    ready_mode = mode;
    pushModel(cnt);
    hs0 = hs_cnt; rd0 = rd_cnt; d0 = done_cnt;
    pulseStart(cnt);
    for (int c = 0; c < 5000 && done_cnt == d0; c++) @(posedge CLOCK_50);
    #1;
    checkOutput("done_seen", 64'(done_cnt - d0), 64'd1);
    hs = hs_cnt - hs0;
    rd = rd_cnt - rd0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    checkOutput({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
    checkOutput({tag, "_pix_x"}, 64'(pix_x), 64'd0);
    checkOutput({tag, "_pix_y"}, 64'(pix_y), 64'd0);
    checkOutput({tag, "_pix_last"}, 64'(pix_last), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
  endtask

  // Ready pattern: 0 = always, 1 = 1,0,0 repeating, other = random.
  initial begin
    int phase = 0;
    forever begin
      @(posedge CLOCK_50); #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = (phase % 3 == 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end
  end

  // Scoreboard: handshakes, stall stability, read addresses, done pulses.
  initial begin
    pix_t cur, held;
    logic stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge CLOCK_50);
      cur = {pix_x, pix_y, pix_last};
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stall_valid", 64'(pix_valid), 64'd1);
          checkOutput("stall_hold", 64'(cur), 64'(held));
        end
        if (pix_valid && pix_ready) begin
          hs_cnt++;
          checkOutput("pix_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) checkOutput("pixel", 64'(cur), 64'(exp_q.pop_front()));
        end
        stalled = pix_valid && !pix_ready;
        held = cur;
        if (mem_rd) begin
          rd_cnt++;
          checkOutput("rd_expected", 64'(addr_q.size() != 0), 64'd1);
          if (addr_q.size() != 0) checkOutput("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs, rd, d0, hs0, rd0;

    setVec(0, 1, 0, 0, 4); setVecRec(0, 0, 12, 15, 4);
    setVec(1, 2, 1, 0, 3); setVecRec(1, 0, 5, 6, 4);    setVecRec(1, 1, 7, 7, 5);
    setVec(2, 2, 0, 1, 1); setVecRec(2, 0, 20, 10, 2);  setVecRec(2, 1, 1, 1, 3);
    setVec(3, 3, 1, 1, 5); setVecRec(3, 0, 0, 2, 0);    setVecRec(3, 1, 100, 101, 511);
                           setVecRec(3, 2, 9, 3, 7);
    setVec(4, 1, 2, 0, 8); setVecRec(4, 0, 2040, 2047, 1);
    setVec(5, 3, 0, 3, 0); setVecRec(5, 0, 5, 4, 1);    setVecRec(5, 1, 2047, 0, 2);
                           setVecRec(5, 2, 1, 0, 3);

    for (int i = 0; i < 512; i++) mem[i] = 31'h0000_07FF;

    repeat (3) @(posedge CLOCK_50);
    #1;
    checkResetState("por");
    rst_n = 1'b1;

    // Cycle-exact latency of a single span with no backpressure.
    ready_mode = 0;
    setRec(0, 12, 15, 4);
    pushModel(1);
    pulseStart(1);
    checkOutput("t_mem_rd", 64'(mem_rd), 64'd1);
    checkOutput("t_mem_addr", 64'(mem_addr), 64'd15);
    checkOutput("t_busy", 64'(busy), 64'd1);
    @(posedge CLOCK_50); #1;
    checkOutput("t_wait_valid", 64'(pix_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLOCK_50); #1;
      checkOutput("t_pix_valid", 64'(pix_valid), 64'd1);
      checkOutput("t_pix_x", 64'(pix_x), 64'(12 + k));
      checkOutput("t_pix_y", 64'(pix_y), 64'd4);
      checkOutput("t_pix_last", 64'(pix_last), 64'(k == 3));
    end
    @(posedge CLOCK_50); #1;
    checkOutput("t_next_valid", 64'(pix_valid), 64'd0);
    checkOutput("t_next_done", 64'(done), 64'd0);
    @(posedge CLOCK_50); #1;
    checkOutput("t_done", 64'(done), 64'd1);
    checkOutput("t_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge CLOCK_50); #1;
    checkOutput("t_done_pulse", 64'(done), 64'd0);
    checkOutput("t_idle_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].cnt; k++)
        setRec(k, int'(vecs[v].l[k]), int'(vecs[v].r[k]), int'(vecs[v].y[k]));
      applyStimulus(vecs[v].cnt, vecs[v].mode, hs, rd);
      checkOutput($sformatf("vec%0d_err_cnt", v), 64'(err_cnt), 64'(vecs[v].exp_err));
      checkOutput($sformatf("vec%0d_pixels", v), 64'(hs), 64'(vecs[v].exp_pix));
      checkOutput($sformatf("vec%0d_reads", v), 64'(rd), 64'(vecs[v].cnt));
      checkOutput($sformatf("vec%0d_sb_left", v), 64'(exp_q.size()), 64'd0);
      checkOutput($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
    end

    // Empty table: done next cycle, never busy, no reads.
    ready_mode = 0;
    d0 = done_cnt; rd0 = rd_cnt;
    pulseStart(0);
    checkOutput("empty_done", 64'(done), 64'd1);
    checkOutput("empty_busy", 64'(busy), 64'd0);
    checkOutput("empty_mem_rd", 64'(mem_rd), 64'd0);
    checkOutput("empty_valid", 64'(pix_valid), 64'd0);
    @(posedge CLOCK_50); #1;
    checkOutput("empty_done_pulse", 64'(done), 64'd0);
    checkOutput("empty_busy2", 64'(busy), 64'd0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("empty_reads", 64'(rd_cnt - rd0), 64'd0);
    checkOutput("empty_done_count", 64'(done_cnt - d0), 64'd1);

    // A second start during EMIT must be ignored.
    setRec(0, 3, 5, 10);
    setRec(1, 0, 0, 11);
    d0 = done_cnt; hs0 = hs_cnt;
    fork
      applyStimulus(2, 0, hs, rd);
      begin
        for (int c = 0; c < 200 && hs_cnt == hs0; c++) @(posedge CLOCK_50);
        #1;
        span_count = ADDR_W'(1);
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
      end
    join
    repeat (6) @(posedge CLOCK_50);
    #1;
    checkOutput("busy_start_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("busy_start_reads", 64'(rd), 64'd2);
    checkOutput("busy_start_pixels", 64'(hs), 64'd4);
    checkOutput("busy_start_sb_left", 64'(exp_q.size() + addr_q.size()), 64'd0);

    // Error counter saturates at 255.
    for (int k = 0; k < 260; k++) setRec(k, 1, 0, 0);
    applyStimulus(260, 0, hs, rd);
    checkOutput("sat_err_cnt", 64'(err_cnt), 64'd255);
    checkOutput("sat_pixels", 64'(hs), 64'd0);
    checkOutput("sat_reads", 64'(rd), 64'd260);

    // Reset after two pixels of the second span aborts the walk cleanly.
    setRec(0, 20, 10, 2);
    setRec(1, 12, 15, 4);
    pushModel(2);
    d0 = done_cnt; hs0 = hs_cnt;
    pulseStart(2);
    for (int c = 0; c < 200 && (hs_cnt - hs0) < 2; c++) @(posedge CLOCK_50);
    #1;
    checkOutput("rst_pixels_before", 64'(hs_cnt - hs0), 64'd2);
    checkOutput("rst_err_before", 64'(err_cnt), 64'd1);
    rst_n = 1'b0;
    @(posedge CLOCK_50); #1;
    checkResetState("midrst");
    exp_q.delete();
    checkOutput("rst_addr_q", 64'(addr_q.size()), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    #1;
    checkOutput("rst_no_done", 64'(done_cnt - d0), 64'd0);
    setRec(0, 12, 15, 4);
    applyStimulus(1, 0, hs, rd);
    checkOutput("restart_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("restart_pixels", 64'(hs), 64'd4);
    checkOutput("restart_reads", 64'(rd), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
